// File: rtl/rom_port_arbiter_if.sv
// Requester-side bus of the pROM arbiter: PicoRV32-style port A, word-address port B, busy flag.
// The arbiter connects through the slave modport; requesters drive through the master modport.
interface rom_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              a_valid;
  logic [31:0]       a_addr;
  logic [3:0]        a_wstrb;
  logic              a_ready;
  logic [31:0]       a_rdata;
  logic              a_err;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic              b_ready;
  logic [31:0]       b_rdata;
  logic              busy;

  modport master (
    output a_valid, a_addr, a_wstrb, b_valid, b_addr,
    input  a_ready, a_rdata, a_err, b_ready, b_rdata, busy
  );

  modport slave (
    input  a_valid, a_addr, a_wstrb, b_valid, b_addr,
    output a_ready, a_rdata, a_err, b_ready, b_rdata, busy
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous pROM between two read requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> RESP, all outputs registered.
module rom_port_arbiter #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               resetn,
  rom_port_arbiter_if.slave  bus,
  output logic               rom_ce,
  output logic               rom_oce,
  output logic               rom_reset,
  output logic [ADDR_W-1:0]  rom_ad,
  input  logic [31:0]        rom_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int                  CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam int                  TAG_W    = 32 - ADDR_W - 2;
  localparam logic [TAG_W-1:0]    BASE_TAG = BASE_ADDR[31:ADDR_W+2];

  state_t             r_state,   w_state_nxt;
  logic               r_last_b,  w_last_b_nxt;   // 1: port B won the last ROM access
  logic               r_grant_b, w_grant_b_nxt;
  logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
  logic [ADDR_W-1:0]  r_rom_ad,  w_rom_ad_nxt;
  logic               r_rom_ce,  w_rom_ce_nxt;
  logic               r_rom_oce;
  logic               r_a_ready, w_a_ready_nxt;
  logic               r_a_err,   w_a_err_nxt;
  logic               r_b_ready, w_b_ready_nxt;
  logic               r_busy,    w_busy_nxt;
  logic [31:0]        r_a_rdata, w_a_rdata_nxt;
  logic [31:0]        r_b_rdata, w_b_rdata_nxt;

  logic w_grant_b;
  logic w_a_bad;

  assign w_grant_b = (bus.a_valid && bus.b_valid) ? ~r_last_b : bus.b_valid;
  assign w_a_bad   = (bus.a_wstrb != 4'h0) || (bus.a_addr[31:ADDR_W+2] != BASE_TAG);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    w_state_nxt   = r_state;
    w_last_b_nxt  = r_last_b;
    w_grant_b_nxt = r_grant_b;
    w_cnt_nxt     = r_cnt;
    w_rom_ad_nxt  = r_rom_ad;
    w_rom_ce_nxt  = 1'b0;
    w_a_ready_nxt = 1'b0;
    w_a_err_nxt   = 1'b0;
    w_b_ready_nxt = 1'b0;
    w_a_rdata_nxt = r_a_rdata;
    w_b_rdata_nxt = r_b_rdata;

    unique case (r_state)
      IDLE: begin
        if (bus.a_valid || bus.b_valid) begin
          w_grant_b_nxt = w_grant_b;
          if (!w_grant_b && w_a_bad) begin
            // Rejected A requests answer straight away without touching the ROM or the rotation.
            w_state_nxt   = RESP;
            w_a_ready_nxt = 1'b1;
            w_a_err_nxt   = 1'b1;
            w_a_rdata_nxt = 32'h0;
          end else begin
            w_state_nxt  = ISSUE;
            w_last_b_nxt = w_grant_b;
            w_rom_ce_nxt = 1'b1;
            w_rom_ad_nxt = w_grant_b ? bus.b_addr : bus.a_addr[ADDR_W+1:2];
          end
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = '0;
      end
      WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = RESP;
          if (r_grant_b) begin
            w_b_rdata_nxt = rom_dout;
            w_b_ready_nxt = 1'b1;
          end else begin
            w_a_rdata_nxt = rom_dout;
            w_a_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      r_state   <= IDLE;
      r_last_b  <= 1'b1;
      r_grant_b <= 1'b0;
      r_cnt     <= '0;
      r_rom_ad  <= '0;
      r_rom_ce  <= 1'b0;
      r_rom_oce <= 1'b1;
      r_a_ready <= 1'b0;
      r_a_err   <= 1'b0;
      r_b_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_a_rdata <= 32'h0;
      r_b_rdata <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_b  <= w_last_b_nxt;
      r_grant_b <= w_grant_b_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rom_ad  <= w_rom_ad_nxt;
      r_rom_ce  <= w_rom_ce_nxt;
      r_rom_oce <= 1'b1;
      r_a_ready <= w_a_ready_nxt;
      r_a_err   <= w_a_err_nxt;
      r_b_ready <= w_b_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_a_rdata <= w_a_rdata_nxt;
      r_b_rdata <= w_b_rdata_nxt;
    end
  end

  assign bus.a_ready = r_a_ready;
  assign bus.a_rdata = r_a_rdata;
  assign bus.a_err   = r_a_err;
  assign bus.b_ready = r_b_ready;
  assign bus.b_rdata = r_b_rdata;
  assign bus.busy    = r_busy;
  assign rom_ce      = r_rom_ce;
  assign rom_oce     = r_rom_oce;
  assign rom_ad      = r_rom_ad;
  assign rom_reset   = ~resetn;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: two instances (RD_LAT=1 and RD_LAT=2), each with a pROM model,
// checked against a transaction-level model of grant order, latency, window errors and data.
module tb_rom_port_arbiter;

  logic clk;
  logic resetn;

  int n_checks = 0;
  int n_fails  = 0;

  rom_port_arbiter_if #(.ADDR_W(10)) if0 ();
  rom_port_arbiter_if #(.ADDR_W(10)) if1 ();

  logic        d_a_valid [2];
  logic [31:0] d_a_addr  [2];
  logic [3:0]  d_a_wstrb [2];
  logic        d_b_valid [2];
  logic [9:0]  d_b_addr  [2];

  logic        o_a_ready [2];
  logic [31:0] o_a_rdata [2];
  logic        o_a_err   [2];
  logic        o_b_ready [2];
  logic [31:0] o_b_rdata [2];
  logic        o_busy    [2];

  logic        rom_ce    [2];
  logic        rom_oce   [2];
  logic        rom_reset [2];
  logic [9:0]  rom_ad    [2];
  logic [31:0] rom_dout  [2];

  assign if0.a_valid = d_a_valid[0];
  assign if0.a_addr  = d_a_addr[0];
  assign if0.a_wstrb = d_a_wstrb[0];
  assign if0.b_valid = d_b_valid[0];
  assign if0.b_addr  = d_b_addr[0];
  assign if1.a_valid = d_a_valid[1];
  assign if1.a_addr  = d_a_addr[1];
  assign if1.a_wstrb = d_a_wstrb[1];
  assign if1.b_valid = d_b_valid[1];
  assign if1.b_addr  = d_b_addr[1];

  assign o_a_ready[0] = if0.a_ready;
  assign o_a_rdata[0] = if0.a_rdata;
  assign o_a_err[0]   = if0.a_err;
  assign o_b_ready[0] = if0.b_ready;
  assign o_b_rdata[0] = if0.b_rdata;
  assign o_busy[0]    = if0.busy;
  assign o_a_ready[1] = if1.a_ready;
  assign o_a_rdata[1] = if1.a_rdata;
  assign o_a_err[1]   = if1.a_err;
  assign o_b_ready[1] = if1.b_ready;
  assign o_b_rdata[1] = if1.b_rdata;
  assign o_busy[1]    = if1.busy;

  rom_port_arbiter #(.ADDR_W(10), .BASE_ADDR(32'h0000_0000), .RD_LAT(1)) dut0 (
    .clk(clk), .resetn(resetn), .bus(if0),
    .rom_ce(rom_ce[0]), .rom_oce(rom_oce[0]), .rom_reset(rom_reset[0]),
    .rom_ad(rom_ad[0]), .rom_dout(rom_dout[0])
  );

  rom_port_arbiter #(.ADDR_W(10), .BASE_ADDR(32'h0000_0000), .RD_LAT(2)) dut1 (
    .clk(clk), .resetn(resetn), .bus(if1),
    .rom_ce(rom_ce[1]), .rom_oce(rom_oce[1]), .rom_reset(rom_reset[1]),
    .rom_ad(rom_ad[1]), .rom_dout(rom_dout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romw(input logic [9:0] w);
    logic [31:0] x;
    x = {22'h0, w};
    if (w == 10'd0) return 32'h14C0_006F;
    return (x * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
  endfunction

  // pROM model: stage 0 is bypass-mode dout, stage 1 the output register; dout is junk outside its valid window.
  logic [31:0] p0 [2];
  logic [31:0] p1 [2];
  int          ce_cnt [2] = '{0, 0};
  logic [9:0]  ce_ad  [2];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      p0[g] <= (rom_ce[g] === 1'b1) ? romw(rom_ad[g]) : 32'hBAD0_BAD0;
      p1[g] <= p0[g];
      if (rom_ce[g] === 1'b1) begin
        ce_cnt[g] <= ce_cnt[g] + 1;
        ce_ad[g]  <= rom_ad[g];
      end
    end
  end
  assign rom_dout[0] = p0[0];
  assign rom_dout[1] = p1[1];

  int lat      [2] = '{1, 2};
  bit exp_last [2] = '{1'b1, 1'b1};   // 1: port B served last

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request on one port, starting at a negedge with the arbiter idle.
  task automatic run_single(input int inst, input bit pb, input logic [31:0] addr,
                            input logic [3:0] wstrb, input string tag);
    bit          exp_err;
    int          exp_n;
    int          n;
    int          ce0;
    bit          done;
    bit          stray;
    logic [9:0]  word;
    logic [31:0] other0;
    word    = pb ? addr[9:0] : addr[11:2];
    exp_err = !pb && ((wstrb != 4'h0) || (addr >= 32'h0000_1000));
    exp_n   = exp_err ? 1 : lat[inst] + 2;
    ce0     = ce_cnt[inst];
    other0  = pb ? o_a_rdata[inst] : o_b_rdata[inst];
    if (pb) begin
      d_b_valid[inst] = 1'b1;
      d_b_addr[inst]  = addr[9:0];
    end else begin
      d_a_valid[inst] = 1'b1;
      d_a_addr[inst]  = addr;
      d_a_wstrb[inst] = wstrb;
    end
    n = 0; done = 0; stray = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (pb ? o_b_ready[inst] : o_a_ready[inst]) done = 1;
      if (pb ? o_a_ready[inst] : o_b_ready[inst]) stray = 1;
    end
    check($sformatf("%s latency", tag), n, exp_n);
    check($sformatf("%s rdata", tag), pb ? o_b_rdata[inst] : o_a_rdata[inst],
          exp_err ? 32'h0 : romw(word));
    if (!pb) check($sformatf("%s a_err", tag), {31'h0, o_a_err[inst]}, {31'h0, exp_err});
    check($sformatf("%s other ready", tag), {31'h0, stray}, 32'h0);
    check($sformatf("%s rom_ce count", tag), ce_cnt[inst] - ce0, exp_err ? 0 : 1);
    if (!exp_err) check($sformatf("%s rom_ad", tag), {22'h0, ce_ad[inst]}, {22'h0, word});
    d_a_valid[inst] = 1'b0;
    d_b_valid[inst] = 1'b0;
    d_a_wstrb[inst] = 4'h0;
    @(negedge clk);
    check($sformatf("%s ready pulse", tag), {31'h0, pb ? o_b_ready[inst] : o_a_ready[inst]}, 32'h0);
    check($sformatf("%s idle busy", tag), {31'h0, o_busy[inst]}, 32'h0);
    check($sformatf("%s other rdata held", tag), pb ? o_a_rdata[inst] : o_b_rdata[inst], other0);
    if (!exp_err) exp_last[inst] = pb;
  endtask

  initial begin
    bit          pb;
    bit          bad;
    int          n;
    logic [31:0] addr;
    logic [31:0] a_cur;
    logic [9:0]  b_cur;

    resetn = 1'b0;
    a_cur  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    b_cur  = 10'($urandom_range(0, 1023));
    for (int i = 0; i < 2; i++) begin
      d_a_valid[i] = 1'b0; d_a_addr[i] = 32'h0; d_a_wstrb[i] = 4'h0;
      d_b_valid[i] = 1'b0; d_b_addr[i] = 10'h0;
    end
    d_a_valid[0] = 1'b1; d_a_addr[0] = a_cur;
    d_b_valid[0] = 1'b1; d_b_addr[0] = b_cur;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d ready", i), {30'h0, o_a_ready[i], o_b_ready[i]}, 32'h0);
      check($sformatf("rst%0d a_err", i), {31'h0, o_a_err[i]}, 32'h0);
      check($sformatf("rst%0d busy", i), {31'h0, o_busy[i]}, 32'h0);
      check($sformatf("rst%0d rdata", i), o_a_rdata[i] | o_b_rdata[i], 32'h0);
      check($sformatf("rst%0d rom_ce", i), {31'h0, rom_ce[i]}, 32'h0);
      check($sformatf("rst%0d rom_oce", i), {31'h0, rom_oce[i]}, 32'h1);
      check($sformatf("rst%0d rom_reset", i), {31'h0, rom_reset[i]}, 32'h1);
      check($sformatf("rst%0d rom_ad", i), {22'h0, rom_ad[i]}, 32'h0);
    end
    resetn = 1'b1;

    // Continuous contention from reset: A first, then strict alternation, one request per RD_LAT+3 cycles.
    n = 0;
    for (int k = 0; k < 4; k++) begin
      bit exp_b;
      bit got;
      exp_b = !exp_last[0];
      got = 0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if (o_a_ready[0] || o_b_ready[0]) got = 1;
      end
      check($sformatf("rr%0d spacing", k), n, (k == 0) ? 3 : 4);
      check($sformatf("rr%0d grant", k), {30'h0, o_a_ready[0], o_b_ready[0]}, {30'h0, !exp_b, exp_b});
      check($sformatf("rr%0d rdata", k), exp_b ? o_b_rdata[0] : o_a_rdata[0],
            exp_b ? romw(b_cur) : romw(a_cur[11:2]));
      exp_last[0] = exp_b;
      if (exp_b) begin
        d_b_valid[0] = 1'b0;
        b_cur = 10'($urandom_range(0, 1023));
        d_b_addr[0] = b_cur;
      end else begin
        d_a_valid[0] = 1'b0;
        a_cur = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        d_a_addr[0] = a_cur;
      end
      if (k == 3) begin
        d_a_valid[0] = 1'b0;
        d_b_valid[0] = 1'b0;
      end
      @(negedge clk);
      check($sformatf("rr%0d pulse", k), {30'h0, o_a_ready[0], o_b_ready[0]}, 32'h0);
      if (k != 3) begin
        d_a_valid[0] = 1'b1;
        d_b_valid[0] = 1'b1;
      end
      n = 1;
    end
    @(negedge clk);

    run_single(0, 1'b0, 32'h0000_0000, 4'h0, "a_word0");
    run_single(0, 1'b1, 32'h0000_03FF, 4'h0, "b_word1023");
    run_single(0, 1'b0, 32'h0000_0010, 4'hF, "a_write");
    run_single(0, 1'b0, 32'h0000_1000, 4'h0, "a_outwin");
    run_single(0, 1'b0, 32'h0000_0FFC, 4'h0, "a_lastword");

    for (int i = 0; i < 8; i++) begin
      pb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) addr = $urandom();
      else addr = {20'h0, 12'($urandom_range(0, 4095))};
      run_single(0, pb, addr, 4'h0, $sformatf("rnd0_%0d", i));
    end

    // Reset while waiting on the ROM aborts silently.
    d_a_valid[0] = 1'b1;
    d_a_addr[0]  = 32'h0000_0020;
    @(negedge clk);
    @(negedge clk);
    check("abort busy in wait", {31'h0, o_busy[0]}, 32'h1);
    resetn = 1'b0;
    d_a_valid[0] = 1'b0;
    @(negedge clk);
    check("abort ready", {31'h0, o_a_ready[0]}, 32'h0);
    check("abort busy", {31'h0, o_busy[0]}, 32'h0);
    check("abort rom_reset", {31'h0, rom_reset[0]}, 32'h1);
    check("abort rom_ce", {31'h0, rom_ce[0]}, 32'h0);
    check("abort a_rdata", o_a_rdata[0], 32'h0);
    resetn = 1'b1;
    exp_last[0] = 1'b1;
    exp_last[1] = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_a_ready[0] || o_b_ready[0] || o_busy[0]) bad = 1;
    end
    check("abort no late ready", {31'h0, bad}, 32'h0);
    check("abort rom_reset released", {31'h0, rom_reset[0]}, 32'h0);
    run_single(0, 1'b0, 32'h0000_0044, 4'h0, "a_after_reset");

    for (int i = 0; i < 16; i++) begin
      pb = 1'($urandom_range(0, 1));
      addr = pb ? {22'h0, 10'($urandom_range(0, 1023))} : {20'h0, 12'($urandom_range(0, 4095))};
      run_single(1, pb, addr, 4'h0, $sformatf("lat2_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
